tcp_tx_msg_noc_if_mq: RTL
=========================

TCP_TX_MSG_NOC_IF_MQ -- requirements
Module: tcp_tx_msg_noc_if_mq

Interface
REQ-001 Parameter SRC_X, default -1: X coordinate inserted as source in response flits.
REQ-002 Parameter SRC_Y, default -1: Y coordinate inserted as source in response flits.
REQ-003 Parameter REQ_FIFO_DEPTH, default 4: outstanding buffer requests held; power of 2, >=2.
REQ-004 Parameter CNT_W, default 16: width of the drop counter.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 noc_in_val / noc_in_data / noc_in_rdy  in/in/out  1/NOC_DATA_WIDTH/1  single-flit request messages from the NoC.
REQ-008 noc_out_val / noc_out_data / noc_out_rdy  out/out/in  1/NOC_DATA_WIDTH/1  single-flit response messages to the NoC.
REQ-009 poller_req_{val,flowid,len,dst_x,dst_y,dst_fbits} / poller_req_rdy  out/in  1,FLOWID_W,RX_PAYLOAD_PTR_W,XY_WIDTH,XY_WIDTH,MSG_SRC_FBITS_WIDTH / 1  buffer request to poller.
REQ-010 poller_meta_{val,flowid,base_ptr,len,dst_x,dst_y,dst_fbits} / poller_meta_rdy  in/out  1,FLOWID_W,TX_PAYLOAD_PTR_W+1,TX_PAYLOAD_PTR_W,XY_WIDTH,XY_WIDTH,MSG_SRC_FBITS_WIDTH / 1  grant metadata from poller.
REQ-011 tail_wr_{val,addr,data} / tail_wr_rdy  out/in  1,FLOWID_W,TX_PAYLOAD_PTR_W+1 / 1  tail-pointer write.
REQ-012 sched_upd_val / sched_upd_cmd / sched_upd_rdy  out/out/in  1,sched_cmd_struct,1  scheduler update.
REQ-013 drop_cnt  out  CNT_W  count of discarded unknown-type flits.

Function
REQ-014 All handshakes SHALL complete on a cycle with val&rdy high; val, once high, SHALL hold with stable data until accepted.
REQ-015 Incoming flit SHALL be decoded through tcp_tx_msg_hdr_struct (MSB-aligned) by msg_type: TX_MSG_REQ, TX_PTR_UPD, else unknown.
REQ-016 Input FSM states IN_IDLE, IN_UPD; noc_in_rdy = (state==IN_IDLE) & ~req_fifo_full.
REQ-017 IN_IDLE, accepted TX_MSG_REQ: {flowid,len,src_x,src_y,src_fbits} pushed into request FIFO same cycle; stay IN_IDLE.
REQ-018 IN_IDLE, accepted TX_PTR_UPD: register flowid and tail_ptr, go IN_UPD; tail_wr_val and sched_upd_val both assert next cycle.
REQ-019 IN_UPD: each of tail_wr_val, sched_upd_val SHALL deassert independently after its own handshake; return to IN_IDLE the cycle after both have completed (either order, or simultaneously).
REQ-020 sched_upd_cmd SHALL carry registered flowid with data_pend_set=1, all other fields 0.
REQ-021 Accepted unknown type: flit discarded, drop_cnt incremented, saturating at all-ones.
REQ-022 poller_req_val = FIFO not empty; fields from FIFO head; pop on poller handshake; push and pop in same cycle allowed when FIFO full only if pop occurs (noc_in_rdy still uses pre-pop full).
REQ-023 Output FSM states OUT_IDLE, OUT_SEND; poller_meta_rdy = (state==OUT_IDLE).
REQ-024 Meta handshake registers all meta fields, go OUT_SEND; noc_out_val asserts next cycle (1-cycle latency).
REQ-025 Response flit: msg_type TX_MSG_RESP, dst from meta, src = SRC_X/SRC_Y/fbits 0, flowid, base_ptr, len; unused bits 0.
REQ-026 OUT_SEND returns to OUT_IDLE on noc_out handshake; back-to-back grants SHALL sustain one flit every 2 cycles.
REQ-027 Input and output paths SHALL operate fully concurrently with no shared stall.

Reset
REQ-028 While rst_n low at a clock edge: both FSMs to IDLE, FIFO empty, drop_cnt 0, all val outputs 0, all rdy outputs 0, held registers 0.
REQ-029 Reset mid-operation SHALL discard queued requests, pending updates and pending response; no output val asserts in the first cycle after release.

Structure
REQ-030 tcp_tx_msg_hdr_struct, msg_type enum (TX_MSG_REQ, TX_PTR_UPD, TX_MSG_RESP) and sched_cmd_struct SHALL live in the shared tcp_misc_pkg.
REQ-031 Request queue SHALL be one sub-module tcp_tx_msg_req_fifo (parametrised width/depth, full/empty, registered storage).

Verification
REQ-032 REQ flowid 3, len 128, src (1,2,0) -> poller_req_val next cycle with identical fields.
REQ-033 5 REQs, depth 4, poller_req_rdy=0 -> 4 accepted, noc_in_rdy low on 5th until one pop, then 5th accepted; FIFO order preserved.
REQ-034 PTR_UPD flowid 7 ptr 0x1040, tail_wr_rdy=1, sched_upd_rdy low 3 cycles -> tail write completes once, sched held 3 cycles, FSM idle the cycle after sched handshake.
REQ-035 Meta flowid 9 base 0x200 len 64 dst (0,1,2), noc_out_rdy=0 for 2 cycles -> flit stable, src=(SRC_X,SRC_Y), poller_meta_rdy low until flit accepted.
REQ-036 3 unknown-type flits then rst_n low 1 cycle during pending update -> drop_cnt 3 then 0, all val low, FIFO empty.

Source files
------------

// File: rtl/tcp_misc_pkg.sv
// Shared TCP TX message types: NoC header layout, message-type codes, scheduler
// command, and the request-queue entry used by the TX message NoC interface.
package tcp_misc_pkg;

  localparam int NOC_DATA_WIDTH      = 128;
  localparam int FLOWID_W            = 8;
  localparam int RX_PAYLOAD_PTR_W    = 16;
  localparam int TX_PAYLOAD_PTR_W    = 16;
  localparam int XY_WIDTH            = 8;
  localparam int MSG_SRC_FBITS_WIDTH = 4;
  localparam int MSG_TYPE_W          = 8;

  typedef enum logic [MSG_TYPE_W-1:0] {
    TX_MSG_REQ  = 8'h31,
    TX_PTR_UPD  = 8'h32,
    TX_MSG_RESP = 8'h33
  } tcp_tx_msg_type_e;

  // One header serves all three message kinds: ptr carries the tail pointer for
  // updates and the base pointer for responses; len is unused by updates.
  typedef struct packed {
    logic [XY_WIDTH-1:0]            dst_x;
    logic [XY_WIDTH-1:0]            dst_y;
    logic [MSG_SRC_FBITS_WIDTH-1:0] dst_fbits;
    tcp_tx_msg_type_e               msg_type;
    logic [XY_WIDTH-1:0]            src_x;
    logic [XY_WIDTH-1:0]            src_y;
    logic [MSG_SRC_FBITS_WIDTH-1:0] src_fbits;
    logic [FLOWID_W-1:0]            flowid;
    logic [TX_PAYLOAD_PTR_W:0]      ptr;
    logic [RX_PAYLOAD_PTR_W-1:0]    len;
  } tcp_tx_msg_hdr_struct;

  localparam int HDR_W = $bits(tcp_tx_msg_hdr_struct);

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    logic                data_pend_set;
    logic                data_pend_clr;
    logic                ack_pend_set;
    logic                ack_pend_clr;
  } sched_cmd_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0]            flowid;
    logic [RX_PAYLOAD_PTR_W-1:0]    len;
    logic [XY_WIDTH-1:0]            src_x;
    logic [XY_WIDTH-1:0]            src_y;
    logic [MSG_SRC_FBITS_WIDTH-1:0] src_fbits;
  } tx_msg_req_entry_t;

  typedef enum logic {IN_IDLE, IN_UPD} in_state_e;
  typedef enum logic {OUT_IDLE, OUT_SEND} out_state_e;

  // Headers sit in the most significant bits of a flit; the rest is zero.
  function automatic logic [NOC_DATA_WIDTH-1:0] hdr_to_flit(input tcp_tx_msg_hdr_struct hdr);
    logic [NOC_DATA_WIDTH-1:0] flit;
    flit = '0;
    flit[NOC_DATA_WIDTH-1 -: HDR_W] = hdr;
    return flit;
  endfunction

endpackage

// File: rtl/tcp_tx_msg_req_fifo.sv
// Small synchronous FIFO holding outstanding buffer requests; DEPTH must be a
// power of two so the extra pointer bit distinguishes full from empty.
module tcp_tx_msg_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_val,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = rd_pop & ~empty;
  assign wr_en = wr_val & (~full | rd_en);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // NOTE: sequential state always uses non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/tcp_tx_msg_noc_if_mq.sv
// NoC-facing front end of the TCP TX message engine: queues buffer requests to
// the poller, fans pointer updates out to tail memory and scheduler, and turns
// poller grants into response flits. Input and output paths are independent.
module tcp_tx_msg_noc_if_mq
  import tcp_misc_pkg::*;
#(
  parameter int SRC_X          = -1,
  parameter int SRC_Y          = -1,
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int CNT_W          = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic                           noc_in_val,
  input  logic [NOC_DATA_WIDTH-1:0]      noc_in_data,
  output logic                           noc_in_rdy,

  output logic                           noc_out_val,
  output logic [NOC_DATA_WIDTH-1:0]      noc_out_data,
  input  logic                           noc_out_rdy,

  output logic                           poller_req_val,
  output logic [FLOWID_W-1:0]            poller_req_flowid,
  output logic [RX_PAYLOAD_PTR_W-1:0]    poller_req_len,
  output logic [XY_WIDTH-1:0]            poller_req_dst_x,
  output logic [XY_WIDTH-1:0]            poller_req_dst_y,
  output logic [MSG_SRC_FBITS_WIDTH-1:0] poller_req_dst_fbits,
  input  logic                           poller_req_rdy,

  input  logic                           poller_meta_val,
  input  logic [FLOWID_W-1:0]            poller_meta_flowid,
  input  logic [TX_PAYLOAD_PTR_W:0]      poller_meta_base_ptr,
  input  logic [TX_PAYLOAD_PTR_W-1:0]    poller_meta_len,
  input  logic [XY_WIDTH-1:0]            poller_meta_dst_x,
  input  logic [XY_WIDTH-1:0]            poller_meta_dst_y,
  input  logic [MSG_SRC_FBITS_WIDTH-1:0] poller_meta_dst_fbits,
  output logic                           poller_meta_rdy,

  output logic                           tail_wr_val,
  output logic [FLOWID_W-1:0]            tail_wr_addr,
  output logic [TX_PAYLOAD_PTR_W:0]      tail_wr_data,
  input  logic                           tail_wr_rdy,

  output logic                           sched_upd_val,
  output sched_cmd_struct                sched_upd_cmd,
  input  logic                           sched_upd_rdy,

  output logic [CNT_W-1:0]               drop_cnt
);

  localparam logic [XY_WIDTH-1:0] SRC_X_BITS = XY_WIDTH'(SRC_X);
  localparam logic [XY_WIDTH-1:0] SRC_Y_BITS = XY_WIDTH'(SRC_Y);

  tcp_tx_msg_hdr_struct      in_hdr;
  tx_msg_req_entry_t         fifo_wr_entry;
  tx_msg_req_entry_t         fifo_rd_entry;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      in_fire;
  in_state_e                 in_state;
  logic [FLOWID_W-1:0]       upd_flowid;
  logic [TX_PAYLOAD_PTR_W:0] upd_tail_ptr;
  logic                      tail_done;
  logic                      sched_done;
  out_state_e                out_state;
  tcp_tx_msg_hdr_struct      resp_hdr;
  tcp_tx_msg_hdr_struct      resp_next;

  // ---------------- input path ----------------
  assign in_hdr     = noc_in_data[NOC_DATA_WIDTH-1 -: HDR_W];
  // Full is the pre-pop value, so a push into a full queue never happens.
  assign noc_in_rdy = rst_n & (in_state == IN_IDLE) & ~fifo_full;
  assign in_fire    = noc_in_val & noc_in_rdy;
  assign fifo_push  = in_fire & (in_hdr.msg_type == TX_MSG_REQ);

  assign fifo_wr_entry = '{flowid:    in_hdr.flowid,
                           len:       in_hdr.len,
                           src_x:     in_hdr.src_x,
                           src_y:     in_hdr.src_y,
                           src_fbits: in_hdr.src_fbits};

  tcp_tx_msg_req_fifo #(
    .WIDTH ($bits(tx_msg_req_entry_t)),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_val  (fifo_push),
    .wr_data (fifo_wr_entry),
    .rd_pop  (poller_req_val & poller_req_rdy),
    .rd_data (fifo_rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign poller_req_val       = ~fifo_empty;
  assign poller_req_flowid    = fifo_rd_entry.flowid;
  assign poller_req_len       = fifo_rd_entry.len;
  assign poller_req_dst_x     = fifo_rd_entry.src_x;
  assign poller_req_dst_y     = fifo_rd_entry.src_y;
  assign poller_req_dst_fbits = fifo_rd_entry.src_fbits;

  // A side is finished once its valid has dropped or is being accepted now.
  assign tail_done  = ~tail_wr_val | tail_wr_rdy;
  assign sched_done = ~sched_upd_val | sched_upd_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_state      <= IN_IDLE;
      tail_wr_val   <= 1'b0;
      sched_upd_val <= 1'b0;
      upd_flowid    <= '0;
      upd_tail_ptr  <= '0;
      drop_cnt      <= '0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (in_fire) begin
            if (in_hdr.msg_type == TX_PTR_UPD) begin
              upd_flowid    <= in_hdr.flowid;
              upd_tail_ptr  <= in_hdr.ptr;
              tail_wr_val   <= 1'b1;
              sched_upd_val <= 1'b1;
              in_state      <= IN_UPD;
            end else if (in_hdr.msg_type != TX_MSG_REQ) begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
          end
        end
        IN_UPD: begin
          if (tail_wr_rdy)   tail_wr_val   <= 1'b0;
          if (sched_upd_rdy) sched_upd_val <= 1'b0;
          if (tail_done && sched_done) in_state <= IN_IDLE;
        end
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  assign tail_wr_addr = upd_flowid;
  assign tail_wr_data = upd_tail_ptr;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it holding a value (inferred latch).
  always_comb begin
    sched_upd_cmd               = '0;
    sched_upd_cmd.flowid        = upd_flowid;
    sched_upd_cmd.data_pend_set = 1'b1;
  end

  // ---------------- output path ----------------
  assign poller_meta_rdy = rst_n & (out_state == OUT_IDLE);

  always_comb begin
    resp_next           = '0;
    resp_next.dst_x     = poller_meta_dst_x;
    resp_next.dst_y     = poller_meta_dst_y;
    resp_next.dst_fbits = poller_meta_dst_fbits;
    resp_next.msg_type  = TX_MSG_RESP;
    resp_next.src_x     = SRC_X_BITS;
    resp_next.src_y     = SRC_Y_BITS;
    resp_next.flowid    = poller_meta_flowid;
    resp_next.ptr       = poller_meta_base_ptr;
    resp_next.len       = poller_meta_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_state   <= OUT_IDLE;
      noc_out_val <= 1'b0;
      resp_hdr    <= '0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (poller_meta_val) begin
            resp_hdr    <= resp_next;
            noc_out_val <= 1'b1;
            out_state   <= OUT_SEND;
          end
        end
        OUT_SEND: begin
          if (noc_out_rdy) begin
            noc_out_val <= 1'b0;
            out_state   <= OUT_IDLE;
          end
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

  assign noc_out_data = hdr_to_flit(resp_hdr);

endmodule
